// File: rtl/branch_predict_front.sv
// ---------------------------------------------------------------------------
// branch_predict_front
//
// Fetch-side branch prediction front end. It holds a 32-entry direct-mapped
// BTB and a 5-bit global history register (BHR). It drives the index of an
// external PHT and combines that PHT's direction with the BTB lookup to form
// the next fetch PC.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   fetch_en          IF stage advancing this cycle
//   pc                fetch PC
//   pht_taken         direction read from the external PHT at pht_idx
//   pht_idx           PHT index (EX update index has priority over fetch)
//   pht_update        PHT counter update strobe (resolving cond. branch)
//   pht_real_taken    resolved direction for the PHT update
//   pred_taken        fetch predicts a redirect
//   pred_next_pc      predicted next fetch PC
//   pred_hist         BHR snapshot used by this fetch (pre-update value)
//   ex_*              resolution information from the EX stage
// ---------------------------------------------------------------------------
module branch_predict_front (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic [31:0] pc,
  input  logic        pht_taken,
  output logic [4:0]  pht_idx,
  output logic        pht_update,
  output logic        pht_real_taken,
  output logic        pred_taken,
  output logic [31:0] pred_next_pc,
  output logic [4:0]  pred_hist,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic [4:0]  ex_hist,
  input  logic        ex_mispredict
);

  // BTB storage. Only the valid bits are control state; tag, target and
  // is_cond are data and are never reset.
  logic [31:0] btb_valid;
  logic [24:0] btb_tag    [32];
  logic [31:0] btb_target [32];
  logic        btb_cond   [32];

  logic [4:0]  bhr;

  logic [4:0]  fetch_idx;
  logic [4:0]  ex_idx;
  logic        hit;
  logic        hit_cond;
  logic        btb_we;
  logic        ex_repair;

  assign fetch_idx = pc[6:2];
  assign ex_idx    = ex_pc[6:2];

  assign hit      = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == pc[31:7]);
  assign hit_cond = btb_cond[fetch_idx];

  assign pht_update     = ex_valid && ex_is_branch;
  assign pht_real_taken = ex_taken;

  // A jump (including the branch+jump encoding) or a taken conditional
  // branch allocates; not-taken branches leave the BTB alone.
  assign btb_we    = ex_valid && (ex_is_jump || (ex_is_branch && ex_taken));
  assign ex_repair = ex_valid && ex_mispredict;

  always_comb begin
    pht_idx = pht_update ? (ex_idx ^ ex_hist) : (fetch_idx ^ bhr);

    // The single PHT port is taken by the EX update, so a conditional hit
    // has no direction to use this cycle and falls through.
    pred_taken = 1'b0;
    if (hit) begin
      if (!hit_cond)       pred_taken = 1'b1;
      else if (!pht_update) pred_taken = pht_taken;
      else                 pred_taken = 1'b0;
    end

    pred_next_pc = pred_taken ? btb_target[fetch_idx] : (pc + 32'd4);
    pred_hist    = bhr;
  end

  // Control state: valid bits and history. Mispredict repair wins over the
  // speculative fetch shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_valid <= '0;
      bhr       <= '0;
    end else begin
      if (btb_we) btb_valid[ex_idx] <= 1'b1;

      if (ex_repair) begin
        if (ex_is_branch) bhr <= {ex_hist[3:0], ex_taken};
        else              bhr <= ex_hist;
      end else if (fetch_en && hit && hit_cond) begin
        bhr <= {bhr[3:0], pred_taken};
      end
    end
  end

  // BTB data arrays. The branch+jump encoding is stored as a jump.
  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_tag[ex_idx]    <= ex_pc[31:7];
      btb_target[ex_idx] <= ex_target;
      btb_cond[ex_idx]   <= ex_is_branch && !ex_is_jump;
    end
  end

endmodule

// File: tb/tb_branch_predict_front.sv
module tb_branch_predict_front;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] pc;
  logic        pht_taken;
  logic [4:0]  pht_idx;
  logic        pht_update;
  logic        pht_real_taken;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic [4:0]  pred_hist;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jump;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [4:0]  ex_hist;
  logic        ex_mispredict;

  int checks = 0;
  int errors = 0;

  branch_predict_front dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc(pc),
    .pht_taken(pht_taken), .pht_idx(pht_idx), .pht_update(pht_update),
    .pht_real_taken(pht_real_taken), .pred_taken(pred_taken),
    .pred_next_pc(pred_next_pc), .pred_hist(pred_hist),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_hist(ex_hist), .ex_mispredict(ex_mispredict)
  );

  always #5 clk = ~clk;

  // Reference model: a table of remembered branches keyed by slot, each
  // remembering the full PC it was learned from, plus history as an integer.
  bit          m_valid [32];
  int unsigned m_pc    [32];
  int unsigned m_tgt   [32];
  bit          m_cond  [32];
  int unsigned m_hist;

  // Outputs captured just before the active edge of the last step.
  logic [31:0] o_npc;
  logic        o_taken, o_upd;
  logic [4:0]  o_idx, o_hist;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 0; fetch_en = 0; pc = 0; pht_taken = 0;
    ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_pc = 0;
    ex_taken = 0; ex_target = 0; ex_hist = 0; ex_mispredict = 0;
  endtask

  // Evaluate one cycle with the currently driven inputs: compare against the
  // model, then advance model and DUT across one rising edge.
  task automatic step(input bit chk);
    int unsigned slot, eslot, nh;
    bit hit, upd, tk, we;
    int unsigned exp_idx, exp_npc;
    #1;
    slot = (pc / 4) % 32;
    eslot = (ex_pc / 4) % 32;
    hit = m_valid[slot] && ((m_pc[slot] / 128) == (pc / 128));
    upd = ex_valid && ex_is_branch;
    if (!hit) tk = 0;
    else if (!m_cond[slot]) tk = 1;
    else if (upd) tk = 0;
    else tk = pht_taken;
    exp_idx = upd ? (eslot ^ ex_hist) : (slot ^ m_hist);
    exp_npc = tk ? m_tgt[slot] : pc + 4;
    o_npc = pred_next_pc; o_taken = pred_taken; o_upd = pht_update;
    o_idx = pht_idx; o_hist = pred_hist;
    if (chk) begin
      check("pred_taken", 32'(pred_taken), 32'(tk));
      check("pred_next_pc", pred_next_pc, exp_npc);
      check("pred_hist", 32'(pred_hist), m_hist);
      check("pht_idx", 32'(pht_idx), exp_idx);
      check("pht_update", 32'(pht_update), 32'(upd));
      check("pht_real_taken", 32'(pht_real_taken), 32'(ex_taken));
    end
    we = ex_valid && (ex_is_jump || (ex_is_branch && ex_taken));
    if (ex_valid && ex_mispredict)
      nh = ex_is_branch ? ((ex_hist * 2 + ex_taken) % 32) : ex_hist;
    else if (fetch_en && hit && m_cond[slot])
      nh = (m_hist * 2 + tk) % 32;
    else
      nh = m_hist;
    @(posedge clk);
    if (reset) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_hist = 0;
    end else begin
      m_hist = nh;
      if (we) begin
        m_valid[eslot] = 1; m_pc[eslot] = ex_pc; m_tgt[eslot] = ex_target;
        m_cond[eslot] = ex_is_branch && !ex_is_jump;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    foreach (m_valid[i]) m_valid[i] = 0;
    m_hist = 0;
    idle_inputs();
    @(negedge clk);
    reset = 1;
    step(0);
    step(1);

    // Post-reset fetch at 0x40
    idle_inputs(); pc = 32'h40; fetch_en = 1;
    step(1);
    check("rst_taken", 32'(o_taken), 0);
    check("rst_npc", o_npc, 32'h44);
    check("rst_idx", 32'(o_idx), 32'h10);
    check("rst_hist", 32'(o_hist), 0);

    // Jump learned at 0x100 -> 0x200
    idle_inputs(); ex_valid = 1; ex_is_jump = 1; ex_taken = 1;
    ex_pc = 32'h100; ex_target = 32'h200; pc = 32'h40;
    step(1);
    idle_inputs(); pc = 32'h100; fetch_en = 1;
    step(1);
    check("jmp_taken", 32'(o_taken), 1);
    check("jmp_npc", o_npc, 32'h200);
    check("jmp_hist", 32'(o_hist), 0);

    // Taken branch learned at 0x80 -> 0x40
    idle_inputs(); ex_valid = 1; ex_is_branch = 1; ex_taken = 1;
    ex_pc = 32'h80; ex_target = 32'h40; pc = 32'h100;
    step(1);
    idle_inputs(); pc = 32'h80; pht_taken = 1; fetch_en = 1;
    step(1);
    check("br_taken", 32'(o_taken), 1);
    check("br_idx", 32'(o_idx), 0);
    check("br_hist_before", 32'(o_hist), 0);

    // Conditional hit while the PHT port is busy with an update
    idle_inputs(); pc = 32'h80; pht_taken = 1; ex_valid = 1; ex_is_branch = 1;
    ex_pc = 32'h300; ex_hist = 5'h03;
    step(1);
    check("busy_hist_after_shift", 32'(o_hist), 1);
    check("busy_idx", 32'(o_idx), 3);
    check("busy_upd", 32'(o_upd), 1);
    check("busy_taken", 32'(o_taken), 0);
    check("busy_npc", o_npc, 32'h84);

    // Force history to 0x1F via non-branch repair, then branch repair wins
    idle_inputs(); ex_valid = 1; ex_is_jump = 1; ex_taken = 1; ex_mispredict = 1;
    ex_pc = 32'h500; ex_target = 32'h600; ex_hist = 5'h1F;
    step(1);
    idle_inputs(); pc = 32'h80; pht_taken = 1; fetch_en = 1;
    ex_valid = 1; ex_mispredict = 1; ex_is_branch = 1; ex_hist = 5'h05;
    ex_pc = 32'h700; ex_taken = 0;
    step(1);
    check("repair_hist_before", 32'(o_hist), 32'h1F);
    idle_inputs(); pc = 32'h40;
    step(1);
    check("repair_hist_after", 32'(o_hist), 32'h0A);

    // Reset overrides a concurrent BTB write to slot 3
    idle_inputs(); reset = 1; ex_valid = 1; ex_is_jump = 1; ex_taken = 1;
    ex_pc = 32'h0C; ex_target = 32'h999;
    step(0);
    idle_inputs(); pc = 32'h0C; fetch_en = 1;
    step(1);
    check("rstw_taken", 32'(o_taken), 0);
    check("rstw_npc", o_npc, 32'h10);
    check("rstw_hist", 32'(o_hist), 0);

    // Same-cycle write is not visible; next cycle it is
    idle_inputs(); pc = 32'h20; ex_valid = 1; ex_is_jump = 1; ex_taken = 1;
    ex_pc = 32'h20; ex_target = 32'h2000;
    step(1);
    check("samecyc_taken", 32'(o_taken), 0);
    idle_inputs(); pc = 32'h20;
    step(1);
    check("nextcyc_npc", o_npc, 32'h2000);

    // Not-taken branch does not allocate; branch+jump allocates as jump
    idle_inputs(); ex_valid = 1; ex_is_branch = 1; ex_pc = 32'h14; ex_target = 32'h77;
    step(1);
    idle_inputs(); pc = 32'h14;
    step(1);
    check("nt_miss", 32'(o_taken), 0);
    idle_inputs(); ex_valid = 1; ex_is_branch = 1; ex_is_jump = 1; ex_taken = 1;
    ex_pc = 32'h18; ex_target = 32'h1000;
    step(1);
    idle_inputs(); pc = 32'h18; fetch_en = 1; pht_taken = 0;
    step(1);
    check("bj_taken", 32'(o_taken), 1);
    step(1);
    check("bj_hist", 32'(o_hist), 0);

    // Randomized traffic over a small PC space so aliasing and hits occur
    for (int n = 0; n < 600; n++) begin
      idle_inputs();
      reset     = ($urandom_range(0, 59) == 0);
      fetch_en  = $urandom_range(0, 3) != 0;
      pc        = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 31) << 2);
      pht_taken = $urandom_range(0, 1);
      ex_valid  = $urandom_range(0, 1);
      ex_is_branch = $urandom_range(0, 2) == 0;
      ex_is_jump   = $urandom_range(0, 3) == 0;
      ex_taken  = ex_is_jump ? 1'b1 : 1'($urandom_range(0, 1));
      ex_pc     = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 31) << 2);
      ex_target = $urandom;
      ex_hist   = 5'($urandom_range(0, 31));
      ex_mispredict = $urandom_range(0, 4) == 0;
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
